// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, instruction size, default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_pipe_reg.sv
// Fetch->decode output register: valid/ready hold, flush and async reset.
module if_pipe_reg #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    input  logic [ADDRESS_WIDTH-1:0] in_pc,
    input  logic                     if_ready,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic                     free
);

    // Free when empty or draining this cycle; a new word may then replace the old one.
    assign free = !if_valid || if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (load && free) begin
            if_valid <= 1'b1;
            if_instr <= in_instr;
            if_pc    <= in_pc;
        end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/state sequencing plus output register to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect raises misalign_err and halts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic                     misalign_err
);

    fetch_state_e             state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     run;
    logic                     free;
    logic                     redirect_take;
    logic                     capture;
    logic [ADDRESS_WIDTH-1:0] redirect_tgt;

    assign run           = (state == ST_RUN);
    assign redirect_take = run && redirect_valid;
    assign capture       = run && !redirect_valid && free;
    // Low bits dropped so the PC stays word aligned whatever the trap setting.
    assign redirect_tgt  = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    assign instr_addr    = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (redirect_take) begin
                        pc <= redirect_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (|redirect_pc[1:0])
                            state <= ST_HALT;
`endif
                    end else if (capture) begin
                        pc <= pc + ADDRESS_WIDTH'(INSTR_BYTES);
                    end
                end
                default: state <= state;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_err <= 1'b0;
        else if (redirect_take && (|redirect_pc[1:0]))
            misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

    if_pipe_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .load    (capture),
        .flush   (redirect_take),
        .in_instr(instr),
        .in_pc   (pc),
        .if_ready(if_ready),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc   (if_pc),
        .free    (free)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr_addr, instr, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready, misalign_err;

    logic [31:0] w_addr, w_instr, w_if_instr, w_if_pc;
    logic        w_if_valid, w_misalign;
    logic        w_ready;
    logic        w_redir;
    logic [31:0] w_redir_pc;

    int n_vec = 0;
    int n_err = 0;

    xfer_t exp_q[$];

    // Reference model state: stage mode, next fetch address, held entry, error flag
    int          mstate;
    logic [31:0] mnpc, mhpc;
    bit          mv, merr;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign instr      = rom_f(instr_addr);
    assign w_instr    = rom_f(w_addr);
    assign w_ready    = 1'b1;
    assign w_redir    = 1'b0;
    assign w_redir_pc = 32'h0;

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .misalign_err(misalign_err)
    );

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .instr_addr(w_addr), .instr(w_instr),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .if_valid(w_if_valid), .if_ready(w_ready), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .misalign_err(w_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mstate = 0;
        mnpc   = 32'h0;
        mhpc   = 32'h0;
        mv     = 1'b0;
        merr   = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, book the expected transfer, advance the model past the edge.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (mv && rdy)
            exp_q.push_back('{pc: mhpc, instr: rom_f(mhpc)});
        @(posedge clk);
        if (mstate == 0) begin
            mstate = 1;
        end else if (mstate == 1) begin
            if (rv) begin
                mnpc = {rpc[31:2], 2'b00};
                mv   = 1'b0;
                if (TRAP && rpc[1:0] != 2'b00) begin
                    merr   = 1'b1;
                    mstate = 2;
                end
            end else if (!mv || rdy) begin
                mv   = 1'b1;
                mhpc = mnpc;
                mnpc = mnpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every transfer the DUT presents must match the head of the queue, in the same cycle.
    always @(negedge clk) begin
        xfer_t e;
        if (!rst) begin
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", if_pc, e.pc);
                    chk("xfer_instr", if_instr, e.instr);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_xfer", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        logic [31:0] r, rpc;
        bit          rdy, rv;
        rst = 1'b1;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        #2;
        chk("rst_if_valid", if_valid, 0);
        chk("rst_instr_addr", instr_addr, 32'h0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Boot cycle, then A, B, C back to back
        cycle(1, 0, 0);
        chk("boot_if_valid", if_valid, 0);
        chk("boot_instr_addr", instr_addr, 32'h0);
        cycle(1, 0, 0);
        chk("seq0_valid", if_valid, 1);
        chk("seq0_pc", if_pc, 32'h0);
        chk("seq0_instr", if_instr, rom_f(32'h0));
        chk("wrap_pc_top", w_if_pc, 32'hFFFF_FFFC);
        cycle(1, 0, 0);
        chk("seq1_pc", if_pc, 32'h4);
        chk("seq1_instr", if_instr, rom_f(32'h4));
        chk("wrap_pc_zero", w_if_pc, 32'h0);
        chk("wrap_valid", w_if_valid, 1);
        cycle(1, 0, 0);
        chk("seq2_pc", if_pc, 32'h8);
        chk("seq2_instr", if_instr, rom_f(32'h8));

        // Back to 0, then stall with B held for three cycles
        cycle(1, 1, 32'h0);
        chk("redir0_valid", if_valid, 0);
        chk("redir0_addr", instr_addr, 32'h0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("pre_stall_pc", if_pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            chk("stall_valid", if_valid, 1);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_instr", if_instr, rom_f(32'h4));
            chk("stall_addr", instr_addr, 32'h8);
        end
        cycle(1, 0, 0);
        chk("unstall_pc", if_pc, 32'h8);
        chk("unstall_instr", if_instr, rom_f(32'h8));

        // Redirect while stalled discards the held word
        cycle(0, 0, 0);
        cycle(0, 1, 32'h40);
        chk("stall_redir_valid", if_valid, 0);
        chk("stall_redir_addr", instr_addr, 32'h40);
        cycle(1, 0, 0);
        chk("redir_pc", if_pc, 32'h40);
        chk("redir_instr", if_instr, rom_f(32'h40));

        // Redirect concurrent with a transfer: old path stops after it
        cycle(1, 1, 32'h80);
        chk("xfer_redir_valid", if_valid, 0);
        cycle(1, 0, 0);
        chk("xfer_redir_pc", if_pc, 32'h80);

        // Misaligned target
        cycle(1, 1, 32'h42);
        chk("mis_valid", if_valid, 0);
        chk("mis_err", misalign_err, TRAP ? 32'd1 : 32'd0);
        chk("mis_addr", instr_addr, 32'h40);
        cycle(1, 0, 0);
        chk("mis_next_valid", if_valid, TRAP ? 32'd0 : 32'd1);
        if (!TRAP) chk("mis_next_pc", if_pc, 32'h40);
        cycle(1, 1, 32'h100);
        chk("halt_redir_addr", instr_addr, TRAP ? 32'h40 : 32'h100);

        // Reset asserted mid-stall acts without a clock edge
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("pre_rst_valid", if_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", if_valid, 0);
        chk("async_rst_addr", instr_addr, 32'h0);
        chk("async_rst_pc", if_pc, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random ready/redirect traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) do_reset();
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 11) == 0);
            r   = $urandom();
            case ($urandom_range(0, 5))
                0: rpc = 32'hFFFF_FFF8;
                1: begin
                    rpc = r;
                    if (rpc[1:0] == 2'b00) rpc[0] = 1'b1;
                end
                default: rpc = {22'h0, r[7:0], 2'b00};
            endcase
            cycle(rdy, rv, rpc);
            chk("rand_addr", instr_addr, mnpc);
            chk("rand_valid", if_valid, {31'h0, mv});
            chk("rand_err", misalign_err, {31'h0, merr});
            if (mv) chk("rand_pc", if_pc, mhpc);
        end

        if_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, byte-address width of PC and instruction memory address.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 instr_addr  output  ADDRESS_WIDTH  byte address to instruction ROM; always equals pc register.
REQ-007 instr  input  DATA_WIDTH  word returned by ROM, combinational from instr_addr, same cycle.
REQ-008 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-009 redirect_pc  input  ADDRESS_WIDTH  redirect target byte address.
REQ-010 if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-011 if_ready  input  1  decode accepts the instruction this cycle.
REQ-012 if_instr  output  DATA_WIDTH  fetched instruction word.
REQ-013 if_pc  output  ADDRESS_WIDTH  address the instruction was fetched from.
REQ-014 misalign_err  output  1  sticky flag: redirect to non-word-aligned target (macro-dependent).

Function
REQ-015 States: BOOT, RUN, HALT; BOOT -> RUN unconditionally one cycle after reset release; RUN -> HALT only per REQ-026; HALT exits only by reset.
REQ-016 Transfer to decode occurs on a cycle with if_valid=1 and if_ready=1.
REQ-017 Output register is "free" when if_valid=0 or a transfer occurs that cycle.
REQ-018 In RUN with output register free and no redirect: capture if_instr<=instr, if_pc<=pc, if_valid<=1, pc<=pc+4; one-cycle latency from address to if_valid.
REQ-019 In RUN with output register not free (if_valid=1, if_ready=0): pc, if_instr, if_pc, if_valid all hold; if_instr stays stable while if_valid=1.
REQ-020 Redirect has priority over capture and stall: pc<=redirect_pc, if_valid<=0 (held instruction discarded even when if_ready=0); fetch from new pc resumes next cycle.
REQ-021 Redirect concurrent with a transfer: the transfer completes; no instruction from the old path issues afterwards.
REQ-022 In BOOT and HALT: no capture, pc holds, if_valid=0; redirect ignored in HALT.
REQ-023 PC increment is modulo 2^ADDRESS_WIDTH; 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
REQ-024 pc[1:0] is always 2'b00 in RUN.

Reset
REQ-025 On rst=1, immediately: pc=RESET_PC, state=BOOT, if_valid=0, if_instr=0, if_pc=0, misalign_err=0; reset asserted mid-transfer discards the held instruction.

Configuration
REQ-026 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_err=1, if_valid<=0, pc<=redirect_pc with bits[1:0] forced to 0, state->HALT.
REQ-027 Macro FETCH_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] silently forced to 2'b00, state stays RUN, misalign_err tied 0.

Structure
REQ-028 Shared package fetch_pkg holds: state enum (BOOT, RUN, HALT), INSTR_BYTES=4 constant, default RESET_PC.
REQ-029 One sub-module if_pipe_reg: output register with valid/ready hold, flush, and async reset; PC/state logic stays in fetch_unit.

Verification
REQ-030 Reset release, RESET_PC=0, ROM[0..2]=A,B,C, if_ready=1 -> BOOT 1 cycle, then if_pc 0,4,8 with A,B,C on consecutive cycles.
REQ-031 if_valid=1 with if_pc=4, if_ready low 3 cycles -> if_instr=B, if_pc=4 and instr_addr=8 constant for 3 cycles; C follows the cycle after if_ready rises.
REQ-032 Stalled at if_pc=8, redirect_pc=0x40 -> next cycle if_valid=0, instr_addr=0x40; following cycle if_pc=0x40 with ROM[16].
REQ-033 RESET_PC=0xFFFF_FFFC, if_ready=1 -> if_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-034 redirect_pc=0x42: macro on -> misalign_err=1, HALT, if_valid stays 0; macro off -> fetch continues from 0x40, misalign_err=0.
REQ-035 rst asserted mid-stall with if_valid=1 -> if_valid=0 and instr_addr=RESET_PC immediately, without waiting for a clock edge.
